// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states,
// ALU control, mux selects and the op-class one-hot bit positions.
package ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
      ALUWB, IEXEC, IWB, BRANCH, JUMP, TRAP, HALT
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam int CLS_W      = 6;
   localparam int CLS_MEM    = 0;
   localparam int CLS_RTYPE  = 1;
   localparam int CLS_BRANCH = 2;
   localparam int CLS_JUMP   = 3;
   localparam int CLS_ITYPE  = 4;
   localparam int CLS_ILL    = 5;

endpackage

// File: rtl/multi_cycle_op_class.sv
// Combinational opcode classifier; exactly one class bit is set for any op.
module multi_cycle_op_class
   import ctrl_pkg::*;
(
   input  logic [5:0]       i_op,
   output logic [CLS_W-1:0] o_cls
);

   always_comb begin
      o_cls = '0;
      case (i_op)
         OP_LW, OP_SW:                      o_cls[CLS_MEM]    = 1'b1;
         OP_R:                              o_cls[CLS_RTYPE]  = 1'b1;
         OP_BEQ, OP_BNE:                    o_cls[CLS_BRANCH] = 1'b1;
         OP_J:                              o_cls[CLS_JUMP]   = 1'b1;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: o_cls[CLS_ITYPE]  = 1'b1;
         default:                           o_cls[CLS_ILL]    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory-ready timeout.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined.
//   FETCH/DECODE   | IR load + PC+4 / branch target precompute, dispatch
//   MEMADR..MEMWR  | address calc, load read, load writeback, store
//   EXEC/ALUWB     | R-type execute / writeback
//   IEXEC/IWB      | immediate execute / writeback
//   BRANCH/JUMP    | conditional / unconditional PC update
//   TRAP/HALT      | unsupported opcode / memory timeout (exit only by reset)
module multi_cycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W      = 3,
   parameter int MEM_WAIT_MAX = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               ir_write,
   output logic               pc_write,
   output logic               branch_eq,
   output logic               branch_ne,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               imm_zext,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               mem_write,
   output logic [1:0]         pc_src,
   output logic               instr_done,
   output logic               illegal,
   output logic               err
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]        perf_cycles,
   output logic [31:0]        perf_instret
`endif
);

   localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err;
   logic [CLS_W-1:0] w_cls;
   logic             w_req_state, w_timeout;
   logic [2:0]       w_alu_op;

   multi_cycle_op_class u_op_class (
      .i_op  (op),
      .o_cls (w_cls)
   );

   assign w_req_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
   // Timeout fires on the wait cycle that would bring the count to the limit.
   assign w_timeout   = (MEM_WAIT_MAX > 0) && w_req_state && !mem_ready &&
                        ((32'(r_wait_cnt) + 32'd1) == 32'(MEM_WAIT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FETCH;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_timeout)
            r_err <= 1'b1;
         if (w_req_state && !mem_ready && (w_next == r_state))
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         else
            r_wait_cnt <= '0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:  if (mem_ready) w_next = DECODE;
         DECODE: begin
            if (w_cls[CLS_MEM])         w_next = MEMADR;
            else if (w_cls[CLS_RTYPE])  w_next = EXEC;
            else if (w_cls[CLS_BRANCH]) w_next = BRANCH;
            else if (w_cls[CLS_JUMP])   w_next = JUMP;
            else if (w_cls[CLS_ITYPE])  w_next = IEXEC;
            else if (w_cls[CLS_ILL])    w_next = TRAP;
         end
         MEMADR: w_next = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  if (mem_ready) w_next = MEMWB;
         MEMWR:  if (mem_ready) w_next = FETCH;
         EXEC:   w_next = ALUWB;
         IEXEC:  w_next = IWB;
         MEMWB, ALUWB, IWB, BRANCH, JUMP, TRAP: w_next = FETCH;
         HALT:   w_next = HALT;
         default: w_next = FETCH;
      endcase
      if (w_timeout)
         w_next = HALT;
   end

   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      imm_zext   = 1'b0;
      w_alu_op   = ALU_ADD;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      pc_src     = PCSRC_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
      // Outputs are forced low for the whole reset interval, not just after an edge.
      if (rst_n) begin
         case (r_state)
            FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_4;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: alu_src_b = SRCB_IMM_SH;
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               mem_req    = 1'b1;
               iord       = 1'b1;
               mem_write  = mem_ready;
               instr_done = mem_ready;
            end
            EXEC: begin
               alu_src_a = 1'b1;
               w_alu_op  = ALU_FUNCT;
            end
            ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               case (op)
                  OP_SLTI: w_alu_op = ALU_SLT;
                  OP_ANDI: begin w_alu_op = ALU_AND; imm_zext = 1'b1; end
                  OP_ORI:  begin w_alu_op = ALU_OR;  imm_zext = 1'b1; end
                  default: w_alu_op = ALU_ADD;
               endcase
            end
            IWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               alu_src_a  = 1'b1;
               w_alu_op   = ALU_SUB;
               pc_src     = PCSRC_ALUOUT;
               branch_eq  = (op == OP_BEQ);
               branch_ne  = (op == OP_BNE);
               instr_done = 1'b1;
            end
            JUMP: begin
               pc_write   = 1'b1;
               pc_src     = PCSRC_JUMP;
               instr_done = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
         endcase
      end
   end

   assign alu_op = ALUOP_W'(w_alu_op);
   assign err    = r_err;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] r_perf_cycles, r_perf_instret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_cycles  <= '0;
         r_perf_instret <= '0;
      end else begin
         if (r_state != HALT)
            r_perf_cycles <= r_perf_cycles + 32'd1;
         if (instr_done)
            r_perf_instret <= r_perf_instret + 32'd1;
      end
   end

   assign perf_cycles  = r_perf_cycles;
   assign perf_instret = r_perf_instret;
`endif

endmodule

// File: doc/multi_cycle_ctrl_fsm.md
Name: multi_cycle_ctrl_fsm

Overview:
Control unit for the multi-cycle MIPS datapath, replacing the single-cycle combinational decoder. Moore FSM sequences fetch/decode/execute/memory/writeback per instruction. Waits on a memory ready handshake with a bounded timeout. ALUOp widens to ALUOP_W bits, and the instruction set extends to bne, andi, ori and slti.

Parameters:
ALUOP_W, 3, width of alu_op; must be ≥3.
MEM_WAIT_MAX, 8, max consecutive not-ready cycles tolerated on a memory access; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  unconditional PC write
branch_eq  out  1  PC write if zero
branch_ne  out  1  PC write if !zero
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2
imm_zext  out  1  zero-extend imm (andi/ori)
alu_op  out  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR
reg_write  out  1  register file write
mem_write  out  1  data store
pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  out  1  1-cycle pulse on the final cycle of each instruction
illegal  out  1  1-cycle pulse on an unsupported opcode
err  out  1  sticky memory-timeout flag

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous, active-low.
- While rst_n=0: state=FETCH, wait counter=0, err=0, all outputs 0.
- After reset release: the FSM starts in FETCH.
- Reset mid-instruction aborts the instruction; no write strobe is asserted afterwards until a new FETCH completes.
- Outputs are decoded from the state only, except the ready-gated strobes below.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, slti 001010, andi 001100, ori 001101.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1.
  - Move to DECODE on mem_ready; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target precompute). Next state by op:
  - lw/sw → MEMADR
  - R → EXEC
  - beq/bne → BRANCH
  - j → JUMP
  - addi/slti/andi/ori → IEXEC
  - otherwise → TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, iord=1. Advance to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1.
  - mem_write is asserted only with mem_ready.
  - On mem_ready: instr_done=1, next state FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, instr_done=1. Next state FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - alu_op: addi → add, slti → slt, andi → and, ori → or.
  - imm_zext=1 for andi/ori only.
  - Next state IWB.
- IWB: reg_write=1, reg_dst=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01; branch_eq for beq, branch_ne for bne; instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Next state FETCH.
- TRAP: illegal=1, instr_done=0. Next state FETCH; the PC has already advanced by 4.
- Latency with mem_ready held high:
  - lw 5 cycles.
  - R, sw and I-type 4 cycles.
  - beq, bne and j 3 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on any state change.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX: go to HALT and set err=1.
  - HALT drives all outputs 0 and is left only by reset.
- mem_ready outside request states is ignored.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] and perf_instret[31:0], both reset to 0.
  - perf_cycles increments every cycle outside reset and HALT.
  - perf_instret increments on each instr_done.
  - Both wrap 0xFFFFFFFF → 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg:
  - opcode localparams
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, TRAP, HALT
  - alu_op codes
  - alu_src_b and pc_src encodings
- Sub-module multi_cycle_op_class: combinational op → one-hot class (mem, rtype, branch, jump, itype, illegal), used by the DECODE transition logic.

Test Plan:
- Reset, then lw (op=100011) with mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write and mem_to_reg in cycle 5; instr_done once.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write only in the ready cycle; total latency 7.
- bne (000101) → branch_ne=1, branch_eq=0, pc_src=01 in cycle 3; andi → imm_zext=1, alu_op=011.
- op=111111 → illegal pulse in cycle 3, no reg_write or mem_write, then FETCH.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH → err=1 after 4 wait cycles, outputs 0; assert rst_n=0 → err=0, state FETCH.
- rst_n pulsed low mid-MEMRD → outputs 0 immediately; after release, FETCH with no MEMWB write. With CTRL_PERF_CNT_EN, perf_instret=0 after reset.
